exe_lsu_req_queue: RTL

Parametrised load/store request queue between the execute stage and the data cache. It accepts one memory request per cycle from the execute stage and checks alignment. It formats byte lanes and write data for a configurable bus width, buffers up to DEPTH requests, and issues them in order over the cache's valid/addr_ok handshake. A flush discards every request the cache has not yet accepted.

---
 rtl/exe_lsu_req_queue.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/exe_lsu_req_queue.sv
// Load/store request queue from execute to data cache: checks alignment, formats lanes, issues in order.
// Latency: a request pushed in cycle N is presented to the cache in cycle N+1 (no bypass).
// Backpressure: i_req_ready drops while DEPTH entries are held; the cache throttles issue via i_data_addr_ok.
//
// Ports:
//   i_clk, i_reset             clock, asynchronous active-high reset
//   i_req_*  / o_req_ready     execute-side request (store flag, size, addr, raw wdata)
//   o_req_ale                  combinational alignment/size exception for the presented request
//   i_flush                    drop every request the cache has not yet accepted
//   o_data_* / i_data_addr_ok  cache-side head entry and its acceptance handshake
//   o_q_count, o_st_pending    occupancy and "a store is still queued" indication
module exe_lsu_req_queue #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_req_valid,
  output logic                       o_req_ready,
  input  logic                       i_req_store,
  input  logic [1:0]                 i_req_size,
  input  logic [ADDR_W-1:0]          i_req_addr,
  input  logic [DATA_W-1:0]          i_req_wdata,
  output logic                       o_req_ale,
  input  logic                       i_flush,
  output logic                       o_data_valid,
  output logic                       o_data_op,
  output logic [2:0]                 o_data_size,
  output logic [ADDR_W-1:0]          o_data_addr,
  output logic [DATA_W/8-1:0]        o_data_wstrb,
  output logic [DATA_W-1:0]          o_data_wdata,
  input  logic                       i_data_addr_ok,
  output logic [$clog2(DEPTH):0]     o_q_count,
  output logic                       o_st_pending
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  // Entry storage, one array per field.
  logic              r_op    [DEPTH];
  logic [1:0]        r_size  [DEPTH];
  logic [ADDR_W-1:0] r_addr  [DEPTH];
  logic [STRB_W-1:0] r_strb  [DEPTH];
  logic [DATA_W-1:0] r_wdata [DEPTH];

  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_st_cnt;

  logic [OFF_W-1:0]  w_off;
  logic [OFF_W-1:0]  w_size_mask;
  logic              w_size_big;
  logic              w_ale;
  logic [STRB_W-1:0] w_strb_base;
  logic [STRB_W-1:0] w_strb;
  logic [DATA_W-1:0] w_wdata;
  logic              w_push;
  logic              w_pop;
  logic              w_push_st;
  logic              w_pop_st;
  logic [PTR_W-1:0]  w_head_nxt;

  assign w_off = i_req_addr[OFF_W-1:0];

  // Alignment: the offset bits below the access size must be zero, and the
  // access may not be wider than the bus.
  always_comb begin
    w_size_mask = '0;
    for (int b = 0; b < OFF_W; b++) begin
      if (b < int'(i_req_size)) begin
        w_size_mask[b] = 1'b1;
      end
    end
  end

  assign w_size_big = int'(i_req_size) > OFF_W;
  assign w_ale      = i_req_valid & (w_size_big | (|(w_off & w_size_mask)));
  assign o_req_ale  = w_ale;

  // Byte strobes: (1<<size) contiguous lanes starting at the bus offset.
  // Only non-ALE requests are stored, so the shifted mask never spills.
  always_comb begin
    w_strb_base = '0;
    for (int b = 0; b < STRB_W; b++) begin
      if (b < (1 << i_req_size)) begin
        w_strb_base[b] = 1'b1;
      end
    end
  end

  assign w_strb = i_req_store ? (w_strb_base << w_off) : '0;

  // Write data: replicate the low 8<<size bits across the bus so every lane
  // carries the correctly positioned byte regardless of offset.
  always_comb begin
    w_wdata = '0;
    for (int i = 0; i < DATA_W; i++) begin
      w_wdata[i] = i_req_wdata[i % (8 << i_req_size)];
    end
  end

  assign o_req_ready  = (r_count != CNT_W'(DEPTH));
  assign o_data_valid = (r_count != '0);

  assign w_push     = i_req_valid & o_req_ready & ~w_ale & ~i_flush;
  assign w_pop      = o_data_valid & i_data_addr_ok;
  assign w_push_st  = w_push & i_req_store;
  assign w_pop_st   = w_pop & r_op[r_head];
  assign w_head_nxt = r_head + PTR_W'(w_pop);

  // Head fields come straight from storage; entries are cleared on reset so
  // they read as zero until the first push.
  assign o_data_op    = r_op[r_head];
  assign o_data_size  = {1'b0, r_size[r_head]};
  assign o_data_addr  = r_addr[r_head];
  assign o_data_wstrb = r_strb[r_head];
  assign o_data_wdata = r_wdata[r_head];

  assign o_q_count    = r_count;
  assign o_st_pending = (r_st_cnt != '0);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int e = 0; e < DEPTH; e++) begin
        r_op[e]    <= 1'b0;
        r_size[e]  <= 2'd0;
        r_addr[e]  <= '0;
        r_strb[e]  <= '0;
        r_wdata[e] <= '0;
      end
    end else if (w_push) begin
      r_op[r_tail]    <= i_req_store;
      r_size[r_tail]  <= i_req_size;
      r_addr[r_tail]  <= i_req_addr;
      r_strb[r_tail]  <= w_strb;
      r_wdata[r_tail] <= w_wdata;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_st_cnt <= '0;
    end else begin
      // A same-cycle pop still counts on flush: the cache took that request.
      r_head <= w_head_nxt;
      if (i_flush) begin
        r_tail   <= w_head_nxt;
        r_count  <= '0;
        r_st_cnt <= '0;
      end else begin
        r_tail   <= r_tail + PTR_W'(w_push);
        r_count  <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        r_st_cnt <= r_st_cnt + CNT_W'(w_push_st) - CNT_W'(w_pop_st);
      end
    end
  end

endmodule
